// File: rtl/pc_gen_stage_if.sv
// rtl/pc_gen_stage_if.sv - fetch PC generator bus: BHT/trap/cache inputs, fetch and IF outputs
interface pc_gen_stage_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  CACHE_READY;
   logic                  CACHE_READY_DATA;
   logic                  PRD_VALID;
   logic [ADDR_WIDTH-1:0] PRD_ADDR;
   logic                  TRAP_VALID;
   logic [ADDR_WIDTH-1:0] TRAP_ADDR;
   logic [ADDR_WIDTH-1:0] PC;
   logic                  PC_VALID;
   logic [ADDR_WIDTH-1:0] IF_PC;
   logic                  IF_VALID;
   logic                  TRAP_ACK;
   logic                  MISALIGN_EXC;

   // PC generator side
   modport master (
      input  CACHE_READY, CACHE_READY_DATA,
      input  PRD_VALID, PRD_ADDR,
      input  TRAP_VALID, TRAP_ADDR,
      output PC, PC_VALID,
      output IF_PC, IF_VALID,
      output TRAP_ACK, MISALIGN_EXC
   );

   // Surrounding fetch logic (BHT, trap unit, caches, IF/ID register)
   modport slave (
      output CACHE_READY, CACHE_READY_DATA,
      output PRD_VALID, PRD_ADDR,
      output TRAP_VALID, TRAP_ADDR,
      input  PC, PC_VALID,
      input  IF_PC, IF_VALID,
      input  TRAP_ACK, MISALIGN_EXC
   );
endinterface

// File: rtl/pc_gen_stage.sv
// rtl/pc_gen_stage.sv - fetch-stage PC generator; optional alignment check via PC_ALIGN_CHECK_EN
module pc_gen_stage #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(32'h0000_1000),
   parameter int                    KILL_SLOTS   = 1
) (
   input  logic           CLK,
   input  logic           RST,
   pc_gen_stage_if.master bus
);

   // Kill counter is two bits wide; keep the slot count inside its legal range.
   localparam int        KILL_CLAMP = (KILL_SLOTS < 1) ? 1 : ((KILL_SLOTS > 3) ? 3 : KILL_SLOTS);
   localparam logic [1:0] KILL_INIT = 2'(KILL_CLAMP);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_KILL = 2'd2
`ifdef PC_ALIGN_CHECK_EN
      ,
      ST_HALT = 2'd3
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
   logic                  if_valid_q, if_valid_d;
   logic [1:0]            kill_cnt_q, kill_cnt_d;
`ifdef PC_ALIGN_CHECK_EN
   logic                  misalign_q, misalign_d;
   logic                  fault;
`endif

   logic                  adv;
   logic                  pc_valid;
   logic [ADDR_WIDTH-1:0] pc_seq;
   logic [ADDR_WIDTH-1:0] target;
   logic [ADDR_WIDTH-1:0] pc_sel;
   logic                  redirect;
   logic [1:0]            kill_dec;
   logic                  trap_ack;

   // Pick the next fetch address: trap beats BHT, BHT beats sequential
   always_comb begin
      adv      = bus.CACHE_READY & bus.CACHE_READY_DATA;
      pc_valid = (state_q == ST_RUN) || (state_q == ST_KILL);
      pc_seq   = pc_q + ADDR_WIDTH'(4);
      target   = pc_seq;
      if (bus.TRAP_VALID) begin
         target = bus.TRAP_ADDR;
      end else if (bus.PRD_VALID) begin
         target = bus.PRD_ADDR;
      end
`ifdef PC_ALIGN_CHECK_EN
      pc_sel = target;
      fault  = (target[1:0] != 2'b00);
`else
      // No alignment checking: word-align whatever the BHT or trap unit supplies.
      pc_sel = target & ~ADDR_WIDTH'(3);
`endif
      // Sequential wrap past the top of the address space is not a redirect.
      redirect = (pc_sel != pc_seq);
      kill_dec = (kill_cnt_q == 2'd0) ? 2'd0 : (kill_cnt_q - 2'd1);
   end

   // Next-state, next-PC and IF slot update; nothing moves without advance
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      kill_cnt_d = kill_cnt_q;
      if_pc_d    = if_pc_q;
      if_valid_d = if_valid_q;
      trap_ack   = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_d = misalign_q;
`endif
      if (adv) begin
         if_pc_d = pc_q;
         case (state_q)
            ST_BOOT: begin
               // PC stays on the reset vector; fetching starts next cycle.
               state_d = ST_RUN;
            end
            ST_RUN, ST_KILL: begin
               trap_ack = bus.TRAP_VALID;
`ifdef PC_ALIGN_CHECK_EN
               if (fault) begin
                  // Misaligned target: keep the PC and stop fetching until a trap.
                  state_d    = ST_HALT;
                  misalign_d = 1'b1;
               end else
`endif
               begin
                  pc_d = pc_sel;
                  if (redirect) begin
                     // Reload, never accumulate, the wrong-path window.
                     kill_cnt_d = KILL_INIT;
                     state_d    = ST_KILL;
                  end else begin
                     kill_cnt_d = kill_dec;
                     state_d    = (kill_dec == 2'd0) ? ST_RUN : ST_KILL;
                  end
               end
            end
`ifdef PC_ALIGN_CHECK_EN
            ST_HALT: begin
               if (bus.TRAP_VALID) begin
                  trap_ack = 1'b1;
                  if (!fault) begin
                     pc_d       = pc_sel;
                     kill_cnt_d = KILL_INIT;
                     state_d    = ST_KILL;
                     misalign_d = 1'b0;
                  end
               end
            end
`endif
            default: begin
               state_d = ST_RUN;
            end
         endcase
         // The redirecting slot is always dropped; after that, a slot is dropped
         // while wrong-path slots are still outstanding once this advance is done.
         if_valid_d = pc_valid & ~redirect & (kill_cnt_d == 2'd0);
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         if_pc_q    <= '0;
         if_valid_q <= 1'b0;
         kill_cnt_q <= 2'd0;
`ifdef PC_ALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_valid_q <= if_valid_d;
         kill_cnt_q <= kill_cnt_d;
`ifdef PC_ALIGN_CHECK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   assign bus.PC       = pc_q;
   assign bus.PC_VALID = pc_valid;
   assign bus.IF_PC    = if_pc_q;
   assign bus.IF_VALID = if_valid_q;
   // Same-cycle acknowledge so a level trap request is consumed exactly once.
   assign bus.TRAP_ACK = trap_ack & ~RST;
`ifdef PC_ALIGN_CHECK_EN
   assign bus.MISALIGN_EXC = misalign_q;
`else
   assign bus.MISALIGN_EXC = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen_stage.sv
// tb/tb_pc_gen_stage.sv - directed bench for pc_gen_stage with reference model (honours PC_ALIGN_CHECK_EN)
module tb_pc_gen_stage;

   localparam int          KILL_SLOTS = 1;
   localparam logic [31:0] RV         = 32'h0000_1000;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   pc_gen_stage_if #(.ADDR_WIDTH(32)) bus ();

   pc_gen_stage #(
      .ADDR_WIDTH  (32),
      .RESET_VECTOR(RV),
      .KILL_SLOTS  (KILL_SLOTS)
   ) u_dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: where fetch is, which IF slot is live, how many wrong-path slots remain.
   bit          known = 1'b0;
   bit          m_boot, m_halt, m_mis, m_if_valid;
   logic [31:0] m_pc, m_if_pc;
   int          m_kill_left;

   task automatic model_step();
      logic [31:0] seq, nxt;
      if (RST) begin
         known = 1'b1; m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0;
         m_pc = RV; m_if_pc = 32'h0; m_if_valid = 1'b0; m_kill_left = 0;
      end else if (known && bus.CACHE_READY && bus.CACHE_READY_DATA) begin
         m_if_pc = m_pc;
         if (m_boot) begin
            m_boot = 1'b0;
            m_if_valid = 1'b0;
         end else begin
            seq = m_pc + 32'd4;
            nxt = bus.TRAP_VALID ? bus.TRAP_ADDR : (bus.PRD_VALID ? bus.PRD_ADDR : seq);
`ifndef PC_ALIGN_CHECK_EN
            nxt = {nxt[31:2], 2'b00};
`endif
            if (m_halt) begin
               m_if_valid = 1'b0;
               if (bus.TRAP_VALID && nxt[1:0] == 2'b00) begin
                  m_halt = 1'b0; m_mis = 1'b0; m_pc = nxt; m_kill_left = KILL_SLOTS - 1;
               end
            end else if (nxt[1:0] != 2'b00) begin
               m_halt = 1'b1; m_mis = 1'b1; m_if_valid = 1'b0;
            end else begin
               if (nxt != seq) begin
                  m_if_valid = 1'b0; m_kill_left = KILL_SLOTS - 1;
               end else if (m_kill_left > 0) begin
                  m_if_valid = 1'b0; m_kill_left--;
               end else begin
                  m_if_valid = 1'b1;
               end
               m_pc = nxt;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge CLK);
      model_step();
   end

   // Compare process: every negedge once reset has been seen
   initial forever begin
      @(negedge CLK);
      if (known) begin
         check("pc",       bus.PC, m_pc);
         check("pc_valid", 32'(bus.PC_VALID), 32'(!m_boot && !m_halt));
         check("if_pc",    bus.IF_PC, m_if_pc);
         check("if_valid", 32'(bus.IF_VALID), 32'(m_if_valid));
         check("misalign", 32'(bus.MISALIGN_EXC), 32'(m_mis));
         check("trap_ack", 32'(bus.TRAP_ACK),
               32'(!RST && bus.CACHE_READY && bus.CACHE_READY_DATA && bus.TRAP_VALID && !m_boot));
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_if(input string tag, input logic [31:0] pc, input logic [31:0] if_pc,
                            input logic if_valid);
      check({tag, ".pc"}, bus.PC, pc);
      check({tag, ".if_pc"}, bus.IF_PC, if_pc);
      check({tag, ".if_valid"}, 32'(bus.IF_VALID), 32'(if_valid));
   endtask

   initial begin
      bus.CACHE_READY = 1'b1; bus.CACHE_READY_DATA = 1'b1;
      bus.PRD_VALID = 1'b0; bus.PRD_ADDR = 32'h0;
      bus.TRAP_VALID = 1'b0; bus.TRAP_ADDR = 32'h0;
      repeat (3) cyc();
      RST = 1'b0;
      // reset state
      expect_if("rst", 32'h1000, 32'h0, 1'b0);
      check("rst.pc_valid", 32'(bus.PC_VALID), 32'd0);
      check("rst.misalign", 32'(bus.MISALIGN_EXC), 32'd0);
      check("model.pc_rst", m_pc, 32'h1000);
      // 1: boot then sequential fetch
      cyc(); expect_if("boot", 32'h1000, 32'h1000, 1'b0);
      check("boot.pc_valid", 32'(bus.PC_VALID), 32'd1);
      cyc(); expect_if("seq1", 32'h1004, 32'h1000, 1'b1);
      cyc(); expect_if("seq2", 32'h1008, 32'h1004, 1'b1);
      // 2: BHT redirect kills one slot
      bus.PRD_VALID = 1'b1; bus.PRD_ADDR = 32'h2000;
      cyc(); expect_if("prd", 32'h2000, 32'h1008, 1'b0);
      bus.PRD_VALID = 1'b0;
      cyc(); expect_if("prd+1", 32'h2004, 32'h2000, 1'b1);
      // 3: I-cache stall freezes everything, trap and prediction ignored
      bus.CACHE_READY = 1'b0; bus.PRD_VALID = 1'b1; bus.PRD_ADDR = 32'h5000;
      bus.TRAP_VALID = 1'b1; bus.TRAP_ADDR = 32'h90;
      #1 check("stall.ack", 32'(bus.TRAP_ACK), 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc(); expect_if("stall", 32'h2004, 32'h2000, 1'b1);
      end
      bus.PRD_VALID = 1'b0; bus.TRAP_VALID = 1'b0; bus.CACHE_READY = 1'b1;
      cyc(); expect_if("resume", 32'h2008, 32'h2004, 1'b1);
      bus.CACHE_READY_DATA = 1'b0;
      repeat (2) cyc();
      expect_if("dstall", 32'h2008, 32'h2004, 1'b1);
      bus.CACHE_READY_DATA = 1'b1;
      cyc(); expect_if("dresume", 32'h200C, 32'h2008, 1'b1);
      // prediction equal to PC+4 is not a redirect
      bus.PRD_VALID = 1'b1; bus.PRD_ADDR = 32'h2010;
      cyc(); expect_if("prd_seq", 32'h2010, 32'h200C, 1'b1);
      bus.PRD_VALID = 1'b0;
      // 4: trap beats prediction
      bus.TRAP_VALID = 1'b1; bus.TRAP_ADDR = 32'h80;
      bus.PRD_VALID = 1'b1; bus.PRD_ADDR = 32'h3000;
      #1 check("trap.ack", 32'(bus.TRAP_ACK), 32'd1);
      cyc(); expect_if("trap", 32'h80, 32'h2010, 1'b0);
      bus.TRAP_VALID = 1'b0; bus.PRD_VALID = 1'b0;
      #1 check("trap.ack_off", 32'(bus.TRAP_ACK), 32'd0);
      cyc(); expect_if("trap+1", 32'h84, 32'h80, 1'b1);
      // back-to-back redirects reload the kill window
      bus.PRD_VALID = 1'b1; bus.PRD_ADDR = 32'h3000;
      cyc(); expect_if("b2b1", 32'h3000, 32'h84, 1'b0);
      bus.PRD_ADDR = 32'h5000;
      cyc(); expect_if("b2b2", 32'h5000, 32'h3000, 1'b0);
      bus.PRD_VALID = 1'b0;
      cyc(); expect_if("b2b3", 32'h5004, 32'h5000, 1'b1);
      // 5: wrap at top of address space
      bus.PRD_VALID = 1'b1; bus.PRD_ADDR = 32'hFFFF_FFF8;
      cyc(); expect_if("hi", 32'hFFFF_FFF8, 32'h5004, 1'b0);
      bus.PRD_VALID = 1'b0;
      cyc(); expect_if("hi+1", 32'hFFFF_FFFC, 32'hFFFF_FFF8, 1'b1);
      cyc(); expect_if("wrap", 32'h0, 32'hFFFF_FFFC, 1'b1);
      cyc(); expect_if("wrap+1", 32'h4, 32'h0, 1'b1);
      check("model.pc_wrap", m_pc, 32'h4);
      // 6: misaligned target
      bus.PRD_VALID = 1'b1; bus.PRD_ADDR = 32'h2002;
      cyc();
      bus.PRD_VALID = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      expect_if("mis", 32'h4, 32'h4, 1'b0);
      check("mis.pc_valid", 32'(bus.PC_VALID), 32'd0);
      check("mis.exc", 32'(bus.MISALIGN_EXC), 32'd1);
      cyc(); expect_if("halt", 32'h4, 32'h4, 1'b0);
      check("halt.exc", 32'(bus.MISALIGN_EXC), 32'd1);
      bus.TRAP_VALID = 1'b1; bus.TRAP_ADDR = 32'h80;
      #1 check("halt.ack", 32'(bus.TRAP_ACK), 32'd1);
      cyc(); expect_if("unhalt", 32'h80, 32'h4, 1'b0);
      check("unhalt.exc", 32'(bus.MISALIGN_EXC), 32'd0);
      check("unhalt.pc_valid", 32'(bus.PC_VALID), 32'd1);
      bus.TRAP_VALID = 1'b0;
      cyc(); expect_if("unhalt+1", 32'h84, 32'h80, 1'b1);
`else
      expect_if("align", 32'h2000, 32'h4, 1'b0);
      check("align.exc", 32'(bus.MISALIGN_EXC), 32'd0);
      cyc(); expect_if("align+1", 32'h2004, 32'h2000, 1'b1);
      bus.TRAP_VALID = 1'b1; bus.TRAP_ADDR = 32'h83;
      cyc(); expect_if("align_trap", 32'h80, 32'h2004, 1'b0);
      bus.TRAP_VALID = 1'b0;
      cyc(); expect_if("align_trap+1", 32'h84, 32'h80, 1'b1);
`endif
      // mid-run reset overrides a pending trap
      RST = 1'b1; bus.TRAP_VALID = 1'b1; bus.TRAP_ADDR = 32'h100;
      #1 check("rst2.ack", 32'(bus.TRAP_ACK), 32'd0);
      cyc(); expect_if("rst2", 32'h1000, 32'h0, 1'b0);
      check("rst2.pc_valid", 32'(bus.PC_VALID), 32'd0);
      RST = 1'b0; bus.TRAP_VALID = 1'b0;
      cyc(); expect_if("rst2.boot", 32'h1000, 32'h1000, 1'b0);
      cyc(); expect_if("rst2.seq", 32'h1004, 32'h1000, 1'b1);
      repeat (2) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
